ram_psum_acc_banked: RTL and testbench



---
 rtl/ram_psum_pkg.sv | 25 ++
 rtl/psum_lane_adder.sv | 36 +++
 rtl/ram_psum_acc_banked.sv | 151 +++++++++++++++
 tb/tb_ram_psum_acc_banked.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_psum_pkg.sv
// Shared types and constant helpers for the partial-sum buffer.
package ram_psum_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        WB
    } psum_state_e;

    // Lane width for a word split into equal signed lanes.
    function automatic int unsigned lane_w(input int unsigned width, input int unsigned lanes);
        return width / lanes;
    endfunction

    // Largest signed value representable in lw bits.
    function automatic longint lane_max(input int unsigned lw);
        return (longint'(1) << (lw - 1)) - 1;
    endfunction

    // Smallest signed value representable in lw bits.
    function automatic longint lane_min(input int unsigned lw);
        return -(longint'(1) << (lw - 1));
    endfunction

endpackage

// File: rtl/psum_lane_adder.sv
// Lane-wise signed adder for psum accumulation; no carry crosses lanes.
// Build option PSUM_SAT_EN: saturate each lane instead of wrapping.
module psum_lane_adder
    import ram_psum_pkg::*;
#(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned LANES = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    localparam int unsigned LANE_W = lane_w(WIDTH, LANES);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LANE_W-1:0] a_l;
        logic [LANE_W-1:0] b_l;
        assign a_l = a[gi*LANE_W +: LANE_W];
        assign b_l = b[gi*LANE_W +: LANE_W];
`ifdef PSUM_SAT_EN
        logic signed [LANE_W:0] full;
        logic                   ovf;
        assign full = $signed({a_l[LANE_W-1], a_l}) + $signed({b_l[LANE_W-1], b_l});
        // Overflow when the extra sign bit disagrees with the lane sign bit.
        assign ovf  = full[LANE_W] ^ full[LANE_W-1];
        assign sum[gi*LANE_W +: LANE_W] = !ovf          ? full[LANE_W-1:0] :
                                          full[LANE_W]  ? LANE_W'(lane_min(LANE_W)) :
                                                          LANE_W'(lane_max(LANE_W));
`else
        // Wrapping keeps only the LSBs, so the carry-out bit is never needed.
        assign sum[gi*LANE_W +: LANE_W] = a_l + b_l;
`endif
    end

endmodule

// File: rtl/ram_psum_acc_banked.sv
// Partial-sum buffer on a single-port SRAM: lane-wise accumulate, clear-on-read,
// zero-init sweep after reset, valid/ready handshakes and held read data.
// Build option PSUM_SAT_EN: saturating lane accumulation (see psum_lane_adder).
module ram_psum_acc_banked
    import ram_psum_pkg::*;
#(
    parameter int unsigned DEPTH_BIT = 6,
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned LANES     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 init_done,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DEPTH_BIT-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 wr_acc,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [DEPTH_BIT-1:0] rd_addr,
    input  logic                 rd_clr,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid
);

    localparam int unsigned DEPTH = 1 << DEPTH_BIT;

    if (WIDTH % LANES != 0) begin : g_width_check
        $error("WIDTH must be a multiple of LANES");
    end

    psum_state_e          state_q;
    logic [DEPTH_BIT-1:0] cnt_q;
    logic [DEPTH_BIT-1:0] wb_addr_q;
    logic [WIDTH-1:0]     operand_q;
    logic                 wb_acc_q;
    logic                 init_done_q;
    logic                 dout_valid_q;
    logic [WIDTH-1:0]     dout_hold_q;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [WIDTH-1:0]     mem_rdata_q;
    logic                 mem_we;
    logic                 mem_re;
    logic [DEPTH_BIT-1:0] mem_addr;
    logic [WIDTH-1:0]     mem_wdata;
    logic [WIDTH-1:0]     acc_sum;
    logic                 rd_accept;

    psum_lane_adder #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_adder (
        .a   (mem_rdata_q),
        .b   (operand_q),
        .sum (acc_sum)
    );

    assign rd_ready   = (state_q == IDLE);
    assign wr_ready   = (state_q == IDLE) && !rd_valid;
    assign rd_accept  = rst_n && (state_q == IDLE) && rd_valid;
    assign init_done  = init_done_q;
    assign dout_valid = dout_valid_q;
    // Fresh SRAM data is shown during the pulse, then the held copy takes over.
    assign dout       = dout_valid_q ? mem_rdata_q : dout_hold_q;

    // SRAM port arbitration: one access per cycle; reset suppresses any pending WB.
    always_comb begin
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = rd_addr;
        mem_wdata = '0;
        if (rst_n) begin
            unique case (state_q)
                INIT: begin
                    mem_we   = 1'b1;
                    mem_addr = cnt_q;
                end
                IDLE: begin
                    if (rd_valid) begin
                        mem_re = 1'b1;
                    end else if (wr_valid) begin
                        mem_addr = wr_addr;
                        if (wr_acc) begin
                            mem_re = 1'b1;
                        end else begin
                            mem_we    = 1'b1;
                            mem_wdata = wr_data;
                        end
                    end
                end
                WB: begin
                    mem_we    = 1'b1;
                    mem_addr  = wb_addr_q;
                    mem_wdata = wb_acc_q ? acc_sum : '0;
                end
                default: ;
            endcase
        end
    end

    // Behavioural single-port SRAM with 1-cycle read latency.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata_q <= mem[mem_addr];
    end

    // Control FSM, init sweep counter, WB context and read-data hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            init_done_q  <= 1'b0;
            wb_addr_q    <= '0;
            operand_q    <= '0;
            wb_acc_q     <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_hold_q  <= '0;
        end else begin
            dout_valid_q <= rd_accept;
            if (dout_valid_q) dout_hold_q <= mem_rdata_q;
            unique case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q     <= IDLE;
                        init_done_q <= 1'b1;
                    end
                end
                IDLE: begin
                    if (rd_valid) begin
                        if (rd_clr) begin
                            wb_addr_q <= rd_addr;
                            wb_acc_q  <= 1'b0;
                            state_q   <= WB;
                        end
                    end else if (wr_valid && wr_acc) begin
                        wb_addr_q <= wr_addr;
                        operand_q <= wr_data;
                        wb_acc_q  <= 1'b1;
                        state_q   <= WB;
                    end
                end
                WB:      state_q <= IDLE;
                default: state_q <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_psum_acc_banked.sv
// Directed self-checking bench for ram_psum_acc_banked (DEPTH_BIT=6, WIDTH=128, LANES=8).
module tb_ram_psum_acc_banked;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         init_done;
    logic         wr_valid;
    logic         wr_ready;
    logic [5:0]   wr_addr;
    logic [127:0] wr_data;
    logic         wr_acc;
    logic         rd_valid;
    logic         rd_ready;
    logic [5:0]   rd_addr;
    logic         rd_clr;
    logic [127:0] dout;
    logic         dout_valid;

    int checks = 0;
    int errors = 0;

    ram_psum_acc_banked #(
        .DEPTH_BIT (6),
        .WIDTH     (128),
        .LANES     (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_done  (init_done),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_acc     (wr_acc),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rd_clr     (rd_clr),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [127:0] lanes8(input logic [15:0] l0, input logic [15:0] l1,
                                            input logic [15:0] l2, input logic [15:0] l3,
                                            input logic [15:0] l4, input logic [15:0] l5,
                                            input logic [15:0] l6, input logic [15:0] l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts posedges until init_done, and how many sweep cycles showed a ready high.
    task automatic wait_init(output int n, output int rdy_seen);
        n = 0;
        rdy_seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!init_done && (rd_ready || wr_ready)) rdy_seen++;
            if (init_done) break;
        end
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [127:0] data, input logic acc);
        wr_addr  = addr;
        wr_data  = data;
        wr_acc   = acc;
        wr_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20 && !wr_ready; k++) @(negedge clk);
        chk("wr_handshake", {127'd0, wr_ready}, 128'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_acc   = 1'b0;
    endtask

    // Returns at the negedge of the cycle after acceptance with dout sampled.
    task automatic do_read(input logic [5:0] addr, input logic clr, output logic [127:0] data);
        rd_addr  = addr;
        rd_clr   = clr;
        rd_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20 && !rd_ready; k++) @(negedge clk);
        chk("rd_handshake", {127'd0, rd_ready}, 128'd1);
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        rd_clr   = 1'b0;
        @(negedge clk);
        chk("rd_pulse", {127'd0, dout_valid}, 128'd1);
        data = dout;
    endtask

    initial begin
        logic [127:0] rdat;
        logic [127:0] pat_p;
        logic [127:0] pat_r;
        int           n;
        int           rdy_seen;

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_acc   = 1'b0;
        rd_valid = 1'b0;
        rd_addr  = '0;
        rd_clr   = 1'b0;

        // 1. Reset values and init sweep
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init_done", {127'd0, init_done}, 128'd0);
        chk("rst_wr_ready", {127'd0, wr_ready}, 128'd0);
        chk("rst_rd_ready", {127'd0, rd_ready}, 128'd0);
        chk("rst_dout", dout, 128'd0);
        chk("rst_dout_valid", {127'd0, dout_valid}, 128'd0);
        rst_n = 1'b1;
        wait_init(n, rdy_seen);
        chk("init_cycles", 128'(n), 128'd64);
        chk("init_ready_low", 128'(rdy_seen), 128'd0);
        chk("init_done_high", {127'd0, init_done}, 128'd1);
        do_read(6'd63, 1'b0, rdat);
        chk("init_addr63", rdat, 128'd0);

        // 2. Overwrite then accumulate; WB steals exactly one cycle
        do_write(6'd5, lanes8(16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h7, 16'h8), 1'b0);
        do_write(6'd5, lanes8(16'h10, 16'h10, 16'h10, 16'h10, 16'h10, 16'h10, 16'h10, 16'h10),
                 1'b1);
        @(negedge clk);
        chk("acc_wb_wr_ready", {127'd0, wr_ready}, 128'd0);
        chk("acc_wb_rd_ready", {127'd0, rd_ready}, 128'd0);
        @(negedge clk);
        chk("acc_idle_wr_ready", {127'd0, wr_ready}, 128'd1);
        do_read(6'd5, 1'b0, rdat);
        chk("acc_result", rdat,
            lanes8(16'h11, 16'h12, 16'h13, 16'h14, 16'h15, 16'h16, 16'h17, 16'h18));

        // 3. Lane overflow behaviour
        do_write(6'd10, lanes8(16'h7FFF, 16'h8000, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF),
                 1'b0);
        do_write(6'd10, lanes8(16'h0001, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0002),
                 1'b1);
        do_read(6'd10, 1'b0, rdat);
`ifdef PSUM_SAT_EN
        chk("ovf_sat", rdat,
            lanes8(16'h7FFF, 16'h8000, 16'h1235, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001));
`else
        chk("ovf_wrap", rdat,
            lanes8(16'h8000, 16'h7FFF, 16'h1235, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001));
`endif

        // 4. Clear-on-read
        do_write(6'd9, 128'h00AB, 1'b0);
        rd_addr  = 6'd9;
        rd_clr   = 1'b1;
        rd_valid = 1'b1;
        @(negedge clk);
        chk("clr_rd_ready", {127'd0, rd_ready}, 128'd1);
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        rd_clr   = 1'b0;
        @(negedge clk);
        chk("clr_dout_valid", {127'd0, dout_valid}, 128'd1);
        chk("clr_dout", dout, 128'h00AB);
        chk("clr_wb_rd_ready", {127'd0, rd_ready}, 128'd0);
        @(negedge clk);
        chk("clr_hold", dout, 128'h00AB);
        chk("clr_pulse_end", {127'd0, dout_valid}, 128'd0);
        do_read(6'd9, 1'b0, rdat);
        chk("clr_reread", rdat, 128'd0);

        // 5. Read/write contention and dout hold
        pat_p = lanes8(16'hA1, 16'hB2, 16'hC3, 16'hD4, 16'hE5, 16'hF6, 16'h17, 16'h28);
        pat_r = lanes8(16'h5555, 16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'hAAAA);
        do_write(6'd20, pat_p, 1'b0);
        do_write(6'd21, 128'hDEAD, 1'b0);
        rd_addr  = 6'd20;
        rd_clr   = 1'b0;
        rd_valid = 1'b1;
        wr_addr  = 6'd21;
        wr_data  = pat_r;
        wr_acc   = 1'b0;
        wr_valid = 1'b1;
        @(negedge clk);
        chk("cont_rd_ready", {127'd0, rd_ready}, 128'd1);
        chk("cont_wr_ready", {127'd0, wr_ready}, 128'd0);
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        @(negedge clk);
        chk("cont_dout_valid", {127'd0, dout_valid}, 128'd1);
        chk("cont_dout", dout, pat_p);
        chk("cont_wr_ready_next", {127'd0, wr_ready}, 128'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_dout", dout, pat_p);
            chk("hold_no_pulse", {127'd0, dout_valid}, 128'd0);
        end
        do_read(6'd21, 1'b0, rdat);
        chk("cont_write_landed", rdat, pat_r);

        // 6. Reset during the WB of an accumulate
        do_write(6'd3, 128'h1111, 1'b0);
        do_write(6'd3, 128'h2222, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_init_done", {127'd0, init_done}, 128'd0);
        chk("mid_rst_wr_ready", {127'd0, wr_ready}, 128'd0);
        chk("mid_rst_rd_ready", {127'd0, rd_ready}, 128'd0);
        chk("mid_rst_dout", dout, 128'd0);
        chk("mid_rst_dout_valid", {127'd0, dout_valid}, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init(n, rdy_seen);
        chk("reinit_cycles", 128'(n), 128'd64);
        chk("reinit_ready_low", 128'(rdy_seen), 128'd0);
        do_read(6'd3, 1'b0, rdat);
        chk("reinit_addr3", rdat, 128'd0);
        do_read(6'd5, 1'b0, rdat);
        chk("reinit_addr5", rdat, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
